// File: rtl/uart_tx_serializer_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_serializer_pkg
// Purpose  : Shared UART definitions: transmitter state encoding, data width
//            limits, oversampling constants and a used-bit mask helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_tx_serializer_pkg;

  localparam int c_DATA_WIDTH_MIN = 5;
  localparam int c_DATA_WIDTH_MAX = 9;

  localparam logic [4:0] c_OS_13 = 5'd13;
  localparam logic [4:0] c_OS_16 = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_MARK   = 3'd6
  } state_t;

  // Mask with the low 'nbits' bits set; bits above the frame length are dropped.
  function automatic logic [c_DATA_WIDTH_MAX-1:0] f_mask(input logic [3:0] nbits);
    logic [c_DATA_WIDTH_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < c_DATA_WIDTH_MAX; i++) begin
      m[i] = (4'(i) < nbits);
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
//------------------------------------------------------------------------------
// Module   : uart_baud_tick_gen
// Purpose  : Produces a one-cycle strobe on the last clk of every bit period
//            (i_divisor * i_os clk cycles). i_restart zeroes both counters so
//            the following cycle is the first cycle of a fresh bit period.
// Ports    : clk, reset (async active-low), i_restart, i_divisor, i_os,
//            o_bit_end
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_restart,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic [4:0]           i_os,
  output logic                 o_bit_end
);

  localparam logic [DIV_WIDTH-1:0] c_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [4:0]           r_os_cnt;
  logic                 w_div_last;
  logic                 w_os_last;

  assign w_div_last = (r_div_cnt == (i_divisor - c_ONE));
  assign w_os_last  = (r_os_cnt == (i_os - 5'd1));
  assign o_bit_end  = w_div_last & w_os_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
    end else if (i_restart) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
    end else if (w_div_last) begin
      r_div_cnt <= '0;
      r_os_cnt  <= w_os_last ? 5'd0 : (r_os_cnt + 5'd1);
    end else begin
      r_div_cnt <= r_div_cnt + c_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_serializer
// Purpose  : UART transmitter. Latches payload and frame configuration on
//            accept and serialises start, LSB-first data, optional parity and
//            1-2 stop bits, with parity / framing error injection.
// Ports    : clk, reset (async active-low), baudDivisor, overSampling,
//            dataBits, parityEnable, parityType, stopBits, parityErrorInject,
//            framingErrorInject, txData, txValid, txReady, tx, frameDone,
//            breakReq (only with UART_TX_BREAK_EN)
// Macro    : UART_TX_BREAK_EN - adds breakReq and the BREAK/MARK sequence.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  baudDivisor,
  input  logic [4:0]            overSampling,
  input  logic [3:0]            dataBits,
  input  logic                  parityEnable,
  input  logic                  parityType,
  input  logic [1:0]            stopBits,
  input  logic                  parityErrorInject,
  input  logic                  framingErrorInject,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
`ifdef UART_TX_BREAK_EN
  input  logic                  breakReq,
`endif
  output logic                  txReady,
  output logic                  tx,
  output logic                  frameDone
);

  localparam logic [3:0] c_NBITS_MIN = 4'(c_DATA_WIDTH_MIN);
  localparam logic [3:0] c_NBITS_MAX = 4'(DATA_WIDTH);

  state_t                       r_state;
  state_t                       w_state_next;
  logic                         r_init;
  logic [DATA_WIDTH-1:0]        r_shift;
  logic [3:0]                   r_bit_cnt;
  logic [3:0]                   r_nbits;
  logic                         r_par_en;
  logic                         r_par_bit;
  logic                         r_fe;
  logic [1:0]                   r_stops;
  logic [DIV_WIDTH-1:0]         r_div;
  logic [4:0]                   r_os;
`ifdef UART_TX_BREAK_EN
  logic [3:0]                   r_brk_need;
`endif

  logic                         w_ready;
  logic                         w_accept;
  logic                         w_restart;
  logic                         w_bit_end;
  logic                         w_tx;
  logic                         w_frame_done;
  logic [3:0]                   w_nbits;
  logic [1:0]                   w_stops;
  logic [DIV_WIDTH-1:0]         w_div;
  logic [4:0]                   w_os;
  logic [c_DATA_WIDTH_MAX-1:0]  w_data_ext;
  logic [c_DATA_WIDTH_MAX-1:0]  w_masked;

  // Configuration clamping, applied to the live inputs at latch time.
  assign w_div   = (baudDivisor == '0) ? DIV_WIDTH'(1) : baudDivisor;
  assign w_os    = (overSampling == c_OS_13) ? c_OS_13 : c_OS_16;
  assign w_nbits = (dataBits < c_NBITS_MIN) ? c_NBITS_MIN :
                   (dataBits > c_NBITS_MAX) ? c_NBITS_MAX : dataBits;
  assign w_stops = (stopBits == 2'd0) ? 2'd1 :
                   (stopBits == 2'd3) ? 2'd2 : stopBits;

  assign w_data_ext = c_DATA_WIDTH_MAX'(txData);
  assign w_masked   = w_data_ext & f_mask(w_nbits);

  // r_init holds txReady low until the first edge after reset release.
`ifdef UART_TX_BREAK_EN
  assign w_ready = r_init & (r_state == S_IDLE) & ~breakReq;
`else
  assign w_ready = r_init & (r_state == S_IDLE);
`endif
  assign w_accept = txValid & w_ready;

  // Bit timing restarts whenever a timed sequence begins.
  assign w_restart = (w_state_next != r_state) &&
                     ((w_state_next == S_START) || (w_state_next == S_BREAK) ||
                      (w_state_next == S_MARK));

  assign txReady   = w_ready;
  assign tx        = w_tx;
  assign frameDone = w_frame_done;

  uart_baud_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_restart),
    .i_divisor (r_div),
    .i_os      (r_os),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx         = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_START;
        end
`ifdef UART_TX_BREAK_EN
        else if (breakReq && r_init) begin
          w_state_next = S_BREAK;
        end
`endif
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end && (r_bit_cnt == (r_nbits - 4'd1))) begin
          w_state_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_tx = r_par_bit;
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        w_tx = ~((r_bit_cnt == 4'd0) & r_fe);
        if (w_bit_end && (r_bit_cnt == ({2'b00, r_stops} - 4'd1))) begin
          w_state_next = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        w_tx = 1'b0;
        if ((r_bit_cnt >= r_brk_need) && !breakReq) begin
          w_state_next = S_MARK;
        end
      end
      S_MARK: begin
        if (w_bit_end) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init     <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_nbits    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_fe       <= 1'b0;
      r_stops    <= '0;
      r_div      <= '0;
      r_os       <= '0;
`ifdef UART_TX_BREAK_EN
      r_brk_need <= '0;
`endif
    end else begin
      r_init <= 1'b1;

      if ((r_state == S_IDLE) && (w_state_next != S_IDLE)) begin
        r_div <= w_div;
        r_os  <= w_os;
      end

      if (w_accept) begin
        r_shift   <= w_masked[DATA_WIDTH-1:0];
        r_nbits   <= w_nbits;
        r_par_en  <= parityEnable;
        r_par_bit <= (^w_masked) ^ parityType ^ parityErrorInject;
        r_fe      <= framingErrorInject;
        r_stops   <= w_stops;
      end

`ifdef UART_TX_BREAK_EN
      if ((r_state == S_IDLE) && (w_state_next == S_BREAK)) begin
        r_brk_need <= 4'd1 + w_nbits + {3'b000, parityEnable} + {2'b00, w_stops};
      end
`endif

      if ((r_state == S_DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end

      // Per-state bit index: zeroed on each state change, saturating count.
      if (w_state_next != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_bit_end && (r_bit_cnt != 4'hF)) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_serializer
// Purpose  : Scoreboard bench for uart_tx_serializer. Stimulus pushes the
//            hand-computed line pattern of each frame; a monitor pops it at
//            every start bit and compares the serial line and frameDone.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_serializer;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [DVW-1:0] baudDivisor = 16'd1;
  logic [4:0]     overSampling = 5'd16;
  logic [3:0]     dataBits = 4'd8;
  logic           parityEnable = 1'b0;
  logic           parityType = 1'b0;
  logic [1:0]     stopBits = 2'd1;
  logic           parityErrorInject = 1'b0;
  logic           framingErrorInject = 1'b0;
  logic [DW-1:0]  txData = '0;
  logic           txValid = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic           breakReq = 1'b0;
`endif
  logic           txReady;
  logic           tx;
  logic           frameDone;

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          bitlen;
    bit          gap;
    bit          abort_ok;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_done = -100;
  bit   mon_en = 1'b1;

  uart_tx_serializer #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .clk                (clk),
    .reset              (reset),
    .baudDivisor        (baudDivisor),
    .overSampling       (overSampling),
    .dataBits           (dataBits),
    .parityEnable       (parityEnable),
    .parityType         (parityType),
    .stopBits           (stopBits),
    .parityErrorInject  (parityErrorInject),
    .framingErrorInject (framingErrorInject),
    .txData             (txData),
    .txValid            (txValid),
`ifdef UART_TX_BREAK_EN
    .breakReq           (breakReq),
`endif
    .txReady            (txReady),
    .tx                 (tx),
    .frameDone          (frameDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge.
  initial begin : monitor
    logic        prev_tx;
    exp_t        e;
    int          total;
    int          unstable;
    int          done_k;
    int          done_n;
    bit          aborted;
    logic [15:0] mid;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_tx = 1'b1;
      end else if (mon_en && prev_tx && !tx) begin
        if (q.size() == 0) begin
          check("unexpected_start", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          if (e.gap) check("b2b_gap", cyc - last_done, 2);
          total    = e.len * e.bitlen;
          unstable = 0;
          done_k   = -1;
          done_n   = 0;
          aborted  = 1'b0;
          mid      = '0;
          for (int k = 0; k < total; k++) begin
            if (k > 0) begin
              @(negedge clk);
              cyc++;
            end
            if (!reset) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== e.pat[k / e.bitlen]) unstable++;
            if ((k % e.bitlen) == (e.bitlen / 2)) mid[k / e.bitlen] = tx;
            if (frameDone) begin
              done_n++;
              if (done_k < 0) done_k = k;
              last_done = cyc;
            end
          end
          check("aborted", aborted, e.abort_ok);
          if (!aborted) begin
            for (int b = 0; b < e.len; b++) begin
              check($sformatf("bit%0d", b), mid[b], e.pat[b]);
            end
            check("bit_cycles_wrong", unstable, 0);
            check("frameDone_pos", done_k, total - 1);
          end
          check("frameDone_count", done_n, aborted ? 0 : 1);
        end
        prev_tx = 1'b1;
      end else begin
        check("idle_frameDone", frameDone, 1'b0);
        prev_tx = tx;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [15:0] div, input logic [4:0] os,
                      input logic [3:0] nb, input bit pe, input bit pt, input logic [1:0] sb,
                      input bit pei, input bit fei, input string pat, input int bitlen,
                      input bit gap, input bit abort_ok, input bit keep);
    exp_t e;
    int   n;
    e.pat = '0;
    for (int i = 0; i < pat.len(); i++) e.pat[i] = (pat[i] == 8'h31);
    e.len      = pat.len();
    e.bitlen   = bitlen;
    e.gap      = gap;
    e.abort_ok = abort_ok;
    q.push_back(e);
    @(negedge clk);
    txData = d; baudDivisor = div; overSampling = os; dataBits = nb;
    parityEnable = pe; parityType = pt; stopBits = sb;
    parityErrorInject = pei; framingErrorInject = fei;
    txValid = 1'b1;
    n = 0;
    while (!txReady && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", txReady, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) begin
      // Disturb every config input mid-frame; the frame must not change.
      txValid = 1'b0;
      baudDivisor = 16'd3; overSampling = 5'd13; dataBits = 4'd6;
      parityEnable = ~pe; stopBits = 2'd2;
      parityErrorInject = ~pei; framingErrorInject = ~fei; txData = ~d;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !txReady) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < 20000), 1'b1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_txReady", txReady, 1'b0);
    check("rst_frameDone", frameDone, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("ready_before_edge", txReady, 1'b0);
    @(negedge clk);
    check("ready_after_release", txReady, 1'b1);

    // data, div, os, bits, pe, pt, stop, pei, fei, pattern, bitlen, gap, abort, keep
    send(8'hA5, 16'd1, 5'd16, 4'd8, 0, 0, 2'd1, 0, 0, "0101001011",  16, 0, 0, 0);
    send(8'h41, 16'd2, 5'd13, 4'd7, 1, 0, 2'd2, 0, 0, "01000001011", 26, 0, 0, 0);
    send(8'h1F, 16'd1, 5'd16, 4'd5, 1, 1, 2'd1, 0, 0, "01111101",    16, 0, 0, 0);
    send(8'hFF, 16'd1, 5'd16, 4'd5, 1, 1, 2'd1, 0, 0, "01111101",    16, 0, 0, 0);
    send(8'h1F, 16'd1, 5'd16, 4'd5, 1, 1, 2'd1, 1, 0, "01111111",    16, 0, 0, 0);
    send(8'h1F, 16'd1, 5'd16, 4'd5, 1, 1, 2'd2, 0, 1, "011111001",   16, 0, 0, 0);
    send(8'h3C, 16'd0, 5'd7,  4'd15, 0, 0, 2'd0, 0, 0, "0001111001", 16, 0, 0, 0);
    send(8'h15, 16'd1, 5'd13, 4'd0, 0, 0, 2'd3, 0, 0, "01010111",    13, 0, 0, 0);
    wait_idle();

    // Back-to-back with txValid held high.
    send(8'h81, 16'd1, 5'd16, 4'd8, 0, 0, 2'd1, 0, 0, "0100000011", 16, 0, 0, 1);
    send(8'h7E, 16'd1, 5'd16, 4'd8, 0, 0, 2'd1, 0, 0, "0011111101", 16, 1, 0, 0);
    wait_idle();

    // Reset in the middle of the data bits while the line is low.
    send(8'h55, 16'd1, 5'd16, 4'd8, 0, 0, 2'd1, 0, 0, "0101010101", 16, 0, 1, 0);
    repeat (70) @(negedge clk);
    check("pre_reset_tx", tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_txReady", txReady, 1'b0);
    check("midrst_frameDone", frameDone, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", txReady, 1'b1);
    send(8'h3C, 16'd1, 5'd16, 4'd8, 0, 0, 2'd1, 0, 0, "0001111001", 16, 0, 0, 0);
    wait_idle();

`ifdef UART_TX_BREAK_EN
    begin : brk
      int nlow;
      int nhigh;
      mon_en = 1'b0;
      baudDivisor = 16'd1; overSampling = 5'd16; dataBits = 4'd8;
      parityEnable = 1'b0; stopBits = 2'd1;
      nlow = 0;
      nhigh = 0;
      @(negedge clk);
      breakReq = 1'b1;
      repeat (300) begin
        @(negedge clk);
        if (!tx) nlow++;
      end
      breakReq = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (txReady) break;
        if (tx) nhigh++;
      end
      check("break_low_cycles", nlow, 300);
      check("mark_high_cycles", nhigh, 16);
      check("break_ready", txReady, 1'b1);
      mon_en = 1'b1;
    end
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, meaning width of the baud divisor input.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port baudDivisor  input  DIV_WIDTH  clk cycles per oversample tick.
REQ-006 SHALL have port overSampling  input  5  ticks per bit (13 or 16).
REQ-007 SHALL have port dataBits  input  4  data bits per frame (5..DATA_WIDTH).
REQ-008 SHALL have port parityEnable  input  1  1 = parity bit sent.
REQ-009 SHALL have port parityType  input  1  0 = even, 1 = odd.
REQ-010 SHALL have port stopBits  input  2  stop bit count (1 or 2).
REQ-011 SHALL have port parityErrorInject  input  1  invert transmitted parity bit.
REQ-012 SHALL have port framingErrorInject  input  1  drive first stop bit low.
REQ-013 SHALL have port txData  input  DATA_WIDTH  payload, LSB first.
REQ-014 SHALL have port txValid  input  1  payload valid.
REQ-015 SHALL have port txReady  output  1  block can accept payload.
REQ-016 SHALL have port tx  output  1  serial line, idle high.
REQ-017 SHALL have port frameDone  output  1  one-cycle pulse at frame end.
REQ-018 SHALL have port breakReq  input  1  request line break (present only with UART_TX_BREAK_EN).

Function
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK, MARK.
REQ-020 SHALL accept a payload when txValid and txReady are both high; txReady SHALL be high only in IDLE.
REQ-021 SHALL latch txData and all config inputs at accept; config changes mid-frame SHALL have no effect.
REQ-022 SHALL drive tx low (START) from the cycle after accept; each bit lasts baudDivisor*overSampling clk cycles.
REQ-023 SHALL transition START->DATA->PARITY (if enabled) else STOP->IDLE, shifting dataBits bits LSB first.
REQ-024 SHALL compute parity as XOR of the dataBits used bits, inverted for odd, then inverted again if parityErrorInject.
REQ-025 SHALL drive the first stop bit low when framingErrorInject, remaining stop bits high.
REQ-026 SHALL pulse frameDone for one cycle on the last clk of the last stop bit, entering IDLE the next cycle (minimum 1-cycle gap between back-to-back frames).
REQ-027 SHALL clamp illegal config at latch: baudDivisor 0 -> 1; overSampling not 13 -> 16; dataBits <5 -> 5, >DATA_WIDTH -> DATA_WIDTH; stopBits 0 -> 1, 3 -> 2.
REQ-028 SHALL ignore txData bits above dataBits.

Reset
REQ-029 SHALL on reset low, immediately: tx=1, txReady=0, frameDone=0, state IDLE, all counters and shift register zero.
REQ-030 SHALL raise txReady on the first clk edge after reset release; reset mid-frame SHALL abort the frame with no frameDone.

Configuration
REQ-031 SHALL with UART_TX_BREAK_EN defined: breakReq high in IDLE (priority over txValid) enters BREAK, tx=0 for at least (1+dataBits+parityEnable+stopBits) bit periods and until breakReq low, then MARK with tx=1 for one bit period, then IDLE; no frameDone.
REQ-032 SHALL without UART_TX_BREAK_EN: no breakReq port, BREAK/MARK unreachable.

Structure
REQ-033 SHALL place the state enum, DATA_WIDTH limits and oversampling constants in the shared UART global package.
REQ-034 SHALL use one sub-module uart_baud_tick_gen producing a one-cycle bit-end strobe from baudDivisor and overSampling, restarted at each accept.

Verification
REQ-035 divisor 1, OS16, 8N1, txData 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1 each 16 cycles; frameDone 160 cycles after start.
REQ-036 divisor 2, OS13, 7 bits even, 2 stop, txData 0x41 -> parity 0, frame 11 bits = 286 cycles.
REQ-037 5 bits odd, txData 0x1F -> parity 0; with parityErrorInject -> parity 1; framingErrorInject -> first stop bit 0.
REQ-038 txValid held high, two payloads -> second start bit exactly 2 cycles after first frameDone.
REQ-039 reset low mid-DATA -> tx=1 same time step, no frameDone; after release 0x3C sends correctly.
REQ-040 (UART_TX_BREAK_EN) 8N1 OS16 div1, breakReq 300 cycles -> tx low 300 cycles, then high 16 cycles, then txReady.
